// File: rtl/fp_addsub_pipe_if.sv
// Operand/result handshake bundle for fp_addsub_pipe.
// The flags signal exists only when FP_ADDSUB_FLAGS_EN is defined.
interface fp_addsub_pipe_if #(
    parameter int BUS_WIDTH = 64
);
    logic                 in_valid;
    logic                 in_ready;
    logic                 op;
    logic [BUS_WIDTH-1:0] A;
    logic [BUS_WIDTH-1:0] B;
    logic                 out_valid;
    logic                 out_ready;
    logic [BUS_WIDTH-1:0] out;
`ifdef FP_ADDSUB_FLAGS_EN
    logic [3:0]           flags;

    modport master (output in_valid, op, A, B, out_ready,
                    input  in_ready, out_valid, out, flags);
    modport slave  (input  in_valid, op, A, B, out_ready,
                    output in_ready, out_valid, out, flags);
`else
    modport master (output in_valid, op, A, B, out_ready,
                    input  in_ready, out_valid, out);
    modport slave  (input  in_valid, op, A, B, out_ready,
                    output in_ready, out_valid, out);
`endif
endinterface

// File: rtl/fp_addsub_pipe.sv
// Three-stage IEEE-754 add/sub (align, add, normalise/round/pack), flush-to-zero,
// valid/ready with global stall. FP_ADDSUB_FLAGS_EN adds the {inv,ovf,unf,inx} flags.
module fp_addsub_pipe #(
    parameter int BUS_WIDTH = 64
) (
    input logic              clk,
    input logic              rst,
    fp_addsub_pipe_if.slave  bus
);
    localparam int EXP_W = (BUS_WIDTH == 32) ? 8 : 11;
    localparam int MAN_W = (BUS_WIDTH == 32) ? 23 : 52;
    localparam int SIG_W = MAN_W + 4;
    localparam int SUM_W = MAN_W + 5;
    localparam int XE_W  = EXP_W + 2;
    localparam int LZ_W  = $clog2(SIG_W + 1);

    localparam logic [EXP_W-1:0]     EXP_MAX = '1;
    localparam logic [BUS_WIDTH-1:0] QNAN    = {1'b0, EXP_MAX, 1'b1, {(MAN_W-1){1'b0}}};
    localparam logic [XE_W-1:0]      XE_ONE  = 1;
    localparam logic [LZ_W-1:0]      LZ_ONE  = 1;

    generate
        if (BUS_WIDTH != 32 && BUS_WIDTH != 64) begin : g_bad_width
            $error("fp_addsub_pipe: BUS_WIDTH must be 32 or 64");
        end
    endgenerate

    logic advance;
    logic out_valid_q;
    logic [BUS_WIDTH-1:0] out_q;

    assign advance       = !out_valid_q || bus.out_ready;
    assign bus.in_ready  = advance;
    assign bus.out_valid = out_valid_q;
    assign bus.out       = out_q;

    // ---------------- stage 1: unpack, classify, swap, align ----------------
    logic                   sa, sb;
    logic [EXP_W-1:0]       ea, eb;
    logic [MAN_W-1:0]       ma, mb;
    logic                   a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic [BUS_WIDTH-2:0]   mag_a, mag_b;
    logic                   swap;
    logic                   x_sign, y_sign;
    logic [EXP_W-1:0]       x_exp, y_exp, exp_diff;
    logic [MAN_W:0]         x_sig, y_sig;
    logic [SIG_W-1:0]       y_ext, lost_mask, y_al;

    assign sa = bus.A[BUS_WIDTH-1];
    assign sb = bus.B[BUS_WIDTH-1] ^ bus.op;
    assign ea = bus.A[BUS_WIDTH-2 -: EXP_W];
    assign eb = bus.B[BUS_WIDTH-2 -: EXP_W];
    assign ma = bus.A[MAN_W-1:0];
    assign mb = bus.B[MAN_W-1:0];

    assign a_zero = (ea == '0);
    assign b_zero = (eb == '0);
    assign a_inf  = (ea == EXP_MAX) && (ma == '0);
    assign b_inf  = (eb == EXP_MAX) && (mb == '0);
    assign a_nan  = (ea == EXP_MAX) && (ma != '0);
    assign b_nan  = (eb == EXP_MAX) && (mb != '0);

    // subnormals are flushed before the magnitude compare so they order as zero
    assign mag_a = a_zero ? '0 : {ea, ma};
    assign mag_b = b_zero ? '0 : {eb, mb};
    assign swap  = (mag_b > mag_a);

    assign x_sign   = swap ? sb : sa;
    assign y_sign   = swap ? sa : sb;
    assign x_exp    = swap ? eb : ea;
    assign y_exp    = swap ? ea : eb;
    assign x_sig    = swap ? (b_zero ? '0 : {1'b1, mb}) : (a_zero ? '0 : {1'b1, ma});
    assign y_sig    = swap ? (a_zero ? '0 : {1'b1, ma}) : (b_zero ? '0 : {1'b1, mb});
    assign exp_diff = x_exp - y_exp;
    assign y_ext    = {y_sig, 3'b000};

    always_comb begin
        lost_mask = ~({SIG_W{1'b1}} << exp_diff);
        if (exp_diff > EXP_W'(SIG_W - 1))
            y_al = {{(SIG_W-1){1'b0}}, |y_sig};
        else
            y_al = (y_ext >> exp_diff) | {{(SIG_W-1){1'b0}}, |(y_ext & lost_mask)};
    end

    logic                 s1_valid_q, s1_xs_q, s1_ys_q;
    logic [EXP_W-1:0]     s1_exp_q;
    logic [SIG_W-1:0]     s1_xsig_q, s1_ysig_q;
    logic                 s1_nan_q, s1_inf_q, s1_inf_sign_q, s1_zero_q, s1_zero_sign_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q     <= 1'b0;
            s1_xs_q        <= 1'b0;
            s1_ys_q        <= 1'b0;
            s1_exp_q       <= '0;
            s1_xsig_q      <= '0;
            s1_ysig_q      <= '0;
            s1_nan_q       <= 1'b0;
            s1_inf_q       <= 1'b0;
            s1_inf_sign_q  <= 1'b0;
            s1_zero_q      <= 1'b0;
            s1_zero_sign_q <= 1'b0;
        end else if (advance) begin
            s1_valid_q     <= bus.in_valid;
            s1_xs_q        <= x_sign;
            s1_ys_q        <= y_sign;
            s1_exp_q       <= x_exp;
            s1_xsig_q      <= {x_sig, 3'b000};
            s1_ysig_q      <= y_al;
            s1_nan_q       <= a_nan || b_nan || (a_inf && b_inf && (sa != sb));
            s1_inf_q       <= a_inf || b_inf;
            s1_inf_sign_q  <= a_inf ? sa : sb;
            s1_zero_q      <= a_zero && b_zero;
            s1_zero_sign_q <= sa && sb;
        end
    end

    // ---------------- stage 2: significand add/subtract ----------------
    logic [SUM_W-1:0] sum_d;
    assign sum_d = (s1_xs_q != s1_ys_q) ? ({1'b0, s1_xsig_q} - {1'b0, s1_ysig_q})
                                        : ({1'b0, s1_xsig_q} + {1'b0, s1_ysig_q});

    logic                 s2_valid_q, s2_sign_q;
    logic [EXP_W-1:0]     s2_exp_q;
    logic [SUM_W-1:0]     s2_sum_q;
    logic                 s2_nan_q, s2_inf_q, s2_inf_sign_q, s2_zero_q, s2_zero_sign_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid_q     <= 1'b0;
            s2_sign_q      <= 1'b0;
            s2_exp_q       <= '0;
            s2_sum_q       <= '0;
            s2_nan_q       <= 1'b0;
            s2_inf_q       <= 1'b0;
            s2_inf_sign_q  <= 1'b0;
            s2_zero_q      <= 1'b0;
            s2_zero_sign_q <= 1'b0;
        end else if (advance) begin
            s2_valid_q     <= s1_valid_q;
            s2_sign_q      <= s1_xs_q;
            s2_exp_q       <= s1_exp_q;
            s2_sum_q       <= sum_d;
            s2_nan_q       <= s1_nan_q;
            s2_inf_q       <= s1_inf_q;
            s2_inf_sign_q  <= s1_inf_sign_q;
            s2_zero_q      <= s1_zero_q;
            s2_zero_sign_q <= s1_zero_sign_q;
        end
    end

    // ---------------- stage 3: normalise, round, pack ----------------
    logic [LZ_W-1:0]      lzc;
    logic                 lz_found;
    logic [SIG_W-1:0]     norm;
    logic [XE_W-1:0]      exp_n, exp_r;
    logic [MAN_W+1:0]     rounded;
    logic [MAN_W-1:0]     man_r;
    logic                 g_bit, r_bit, s_bit, rup;
    logic                 exp_ovf, exp_unf, exact_zero, normal_path;
    logic [BUS_WIDTH-1:0] res_d;

    always_comb begin
        lzc      = '0;
        lz_found = 1'b0;
        for (int i = SIG_W - 1; i >= 0; i--) begin
            if (!lz_found) begin
                if (s2_sum_q[i]) lz_found = 1'b1;
                else             lzc      = lzc + LZ_ONE;
            end
        end
    end

    always_comb begin
        if (s2_sum_q[SUM_W-1]) begin
            norm  = {s2_sum_q[SUM_W-1:2], |s2_sum_q[1:0]};
            exp_n = {2'b00, s2_exp_q} + XE_ONE;
        end else begin
            norm  = s2_sum_q[SIG_W-1:0] << lzc;
            exp_n = {2'b00, s2_exp_q} - {{(XE_W-LZ_W){1'b0}}, lzc};
        end
        g_bit   = norm[2];
        r_bit   = norm[1];
        s_bit   = norm[0];
        rup     = g_bit && (r_bit || s_bit || norm[3]);
        rounded = {1'b0, norm[SIG_W-1:3]} + {{(MAN_W+1){1'b0}}, rup};
        if (rounded[MAN_W+1]) begin
            exp_r = exp_n + XE_ONE;
            man_r = rounded[MAN_W:1];
        end else begin
            exp_r = exp_n;
            man_r = rounded[MAN_W-1:0];
        end
        exp_unf = exp_r[XE_W-1] || (exp_r == '0);
        exp_ovf = !exp_r[XE_W-1] && (exp_r >= {2'b00, EXP_MAX});
    end

    always_comb begin
        exact_zero  = (s2_sum_q == '0);
        normal_path = !s2_nan_q && !s2_inf_q && !s2_zero_q && !exact_zero;
        res_d       = {s2_sign_q, exp_r[EXP_W-1:0], man_r};
        if (s2_nan_q)
            res_d = QNAN;
        else if (s2_inf_q)
            res_d = {s2_inf_sign_q, EXP_MAX, {MAN_W{1'b0}}};
        else if (s2_zero_q)
            res_d = {s2_zero_sign_q, {(BUS_WIDTH-1){1'b0}}};
        else if (exact_zero)
            res_d = '0;
        else if (exp_ovf)
            res_d = {s2_sign_q, EXP_MAX, {MAN_W{1'b0}}};
        else if (exp_unf)
            res_d = {s2_sign_q, {(BUS_WIDTH-1){1'b0}}};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_q       <= '0;
        end else if (advance) begin
            out_valid_q <= s2_valid_q;
            if (s2_valid_q) out_q <= res_d;
        end
    end

`ifdef FP_ADDSUB_FLAGS_EN
    logic [3:0] flags_d, flags_q;

    assign flags_d = {s2_nan_q,
                      normal_path && exp_ovf,
                      normal_path && exp_unf,
                      normal_path && (g_bit || r_bit || s_bit || exp_ovf || exp_unf)};

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                          flags_q <= '0;
        else if (advance && s2_valid_q)   flags_q <= flags_d;
    end

    assign bus.flags = flags_q;
`endif
endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Directed bench for fp_addsub_pipe: one 32-bit and one 64-bit instance,
// hand-computed results, latency, back-pressure and mid-flight reset.
module tb_fp_addsub_pipe;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    fp_addsub_pipe_if #(.BUS_WIDTH(32)) b32 ();
    fp_addsub_pipe_if #(.BUS_WIDTH(64)) b64 ();

    fp_addsub_pipe #(.BUS_WIDTH(32)) u_dut32 (.clk(clk), .rst(rst), .bus(b32));
    fp_addsub_pipe #(.BUS_WIDTH(64)) u_dut64 (.clk(clk), .rst(rst), .bus(b64));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic run32(input string tag, input logic o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input logic [3:0] ef);
        @(negedge clk);
        b32.in_valid = 1'b1; b32.op = o; b32.A = a; b32.B = b;
        @(posedge clk); #1;
        b32.in_valid = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        check({tag, "_valid"}, {63'd0, b32.out_valid}, 64'd1);
        check(tag, {32'd0, b32.out}, {32'd0, exp});
`ifdef FP_ADDSUB_FLAGS_EN
        check({tag, "_flags"}, {60'd0, b32.flags}, {60'd0, ef});
`endif
    endtask

    task automatic run64(input string tag, input logic o, input logic [63:0] a,
                         input logic [63:0] b, input logic [63:0] exp, input logic [3:0] ef);
        @(negedge clk);
        b64.in_valid = 1'b1; b64.op = o; b64.A = a; b64.B = b;
        @(posedge clk); #1;
        b64.in_valid = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        check({tag, "_valid"}, {63'd0, b64.out_valid}, 64'd1);
        check(tag, b64.out, exp);
`ifdef FP_ADDSUB_FLAGS_EN
        check({tag, "_flags"}, {60'd0, b64.flags}, {60'd0, ef});
`endif
    endtask

    task automatic drive32(input logic o, input logic [31:0] a, input logic [31:0] b);
        b32.in_valid = 1'b1; b32.op = o; b32.A = a; b32.B = b;
    endtask

    initial begin
        b32.in_valid = 1'b0; b32.op = 1'b0; b32.A = '0; b32.B = '0; b32.out_ready = 1'b1;
        b64.in_valid = 1'b0; b64.op = 1'b0; b64.A = '0; b64.B = '0; b64.out_ready = 1'b1;

        // reset state
        @(posedge clk); #1;
        check("rst_valid32", {63'd0, b32.out_valid}, 64'd0);
        check("rst_out32",   {32'd0, b32.out}, 64'd0);
        check("rst_valid64", {63'd0, b64.out_valid}, 64'd0);
`ifdef FP_ADDSUB_FLAGS_EN
        check("rst_flags32", {60'd0, b32.flags}, 64'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("in_ready_after_rst", {63'd0, b32.in_ready}, 64'd1);

        // latency: 1.0 + 2.0 = 3.0, valid exactly on the third edge
        @(negedge clk);
        drive32(1'b0, 32'h3F800000, 32'h40000000);
        @(posedge clk); #1;
        b32.in_valid = 1'b0;
        check("lat_c1_valid", {63'd0, b32.out_valid}, 64'd0);
        @(posedge clk); #1;
        check("lat_c2_valid", {63'd0, b32.out_valid}, 64'd0);
        @(posedge clk); #1;
        check("lat_c3_valid", {63'd0, b32.out_valid}, 64'd1);
        check("lat_c3_out",   {32'd0, b32.out}, 64'h40400000);

        run32("sub_equal",   1'b1, 32'h3F800000, 32'h3F800000, 32'h00000000, 4'b0000);
        run32("negz_negz",   1'b0, 32'h80000000, 32'h80000000, 32'h80000000, 4'b0000);
        run32("posz_negz",   1'b0, 32'h00000000, 32'h80000000, 32'h00000000, 4'b0000);
        run32("inf_m_inf",   1'b1, 32'h7F800000, 32'h7F800000, 32'h7FC00000, 4'b1000);
        run32("max_p_max",   1'b0, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 4'b0101);
        run32("three_m_one", 1'b1, 32'h40400000, 32'h3F800000, 32'h40000000, 4'b0000);
        run32("one_p_m1p5",  1'b0, 32'h3F800000, 32'hBFC00000, 32'hBF000000, 4'b0000);
        run32("subn_flush",  1'b0, 32'h00000001, 32'h3F800000, 32'h3F800000, 4'b0000);
        run32("ftz_result",  1'b1, 32'h00800001, 32'h00800000, 32'h00000000, 4'b0011);
        run32("round_up",    1'b0, 32'h3F800000, 32'h33C00000, 32'h3F800001, 4'b0001);
        run32("inf_p_one",   1'b0, 32'h7F800000, 32'h3F800000, 32'h7F800000, 4'b0000);
        run32("one_m_inf",   1'b1, 32'h3F800000, 32'h7F800000, 32'hFF800000, 4'b0000);
        run32("nan_in",      1'b0, 32'h7F800001, 32'h3F800000, 32'h7FC00000, 4'b1000);

        run64("dp_tie_even", 1'b0, 64'h3FF0000000000000, 64'h3CA0000000000000,
              64'h3FF0000000000000, 4'b0001);
        run64("dp_one_p_two", 1'b0, 64'h3FF0000000000000, 64'h4000000000000000,
              64'h4008000000000000, 4'b0000);
        run64("dp_inf_m_inf", 1'b1, 64'h7FF0000000000000, 64'h7FF0000000000000,
              64'h7FF8000000000000, 4'b1000);

        // back-pressure: three ops fill the pipe, the fourth is held off
        @(negedge clk);
        b32.out_ready = 1'b0;
        drive32(1'b0, 32'h3F800000, 32'h40000000);
        #1 check("bp_rdy1", {63'd0, b32.in_ready}, 64'd1);
        @(negedge clk);
        drive32(1'b1, 32'h40400000, 32'h3F800000);
        #1 check("bp_rdy2", {63'd0, b32.in_ready}, 64'd1);
        @(negedge clk);
        drive32(1'b0, 32'h3F800000, 32'hBFC00000);
        #1 check("bp_rdy3", {63'd0, b32.in_ready}, 64'd1);
        @(negedge clk);
        drive32(1'b0, 32'h40000000, 32'h40000000);
        #1;
        check("bp_rdy4_blocked", {63'd0, b32.in_ready}, 64'd0);
        check("bp_valid", {63'd0, b32.out_valid}, 64'd1);
        check("bp_out_r1", {32'd0, b32.out}, 64'h40400000);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check($sformatf("bp_hold_valid%0d", i), {63'd0, b32.out_valid}, 64'd1);
            check($sformatf("bp_hold_out%0d", i), {32'd0, b32.out}, 64'h40400000);
        end
        @(negedge clk);
        b32.out_ready = 1'b1;
        #1 check("bp_release_rdy", {63'd0, b32.in_ready}, 64'd1);
        @(posedge clk); #1;
        b32.in_valid = 1'b0;
        check("bp_drain_r2", {32'd0, b32.out}, 64'h40000000);
        @(posedge clk); #1;
        check("bp_drain_r3", {32'd0, b32.out}, 64'hBF000000);
        @(posedge clk); #1;
        check("bp_drain_r4_valid", {63'd0, b32.out_valid}, 64'd1);
        check("bp_drain_r4", {32'd0, b32.out}, 64'h40800000);
        @(posedge clk); #1;
        check("bp_empty", {63'd0, b32.out_valid}, 64'd0);

        // reset with two operations in flight
        @(negedge clk);
        b32.out_ready = 1'b0;
        drive32(1'b0, 32'h3F800000, 32'h40000000);
        @(negedge clk);
        drive32(1'b1, 32'h40400000, 32'h3F800000);
        @(posedge clk); #1;
        b32.in_valid = 1'b0;
        @(posedge clk); #1;
        check("rf_valid_before", {63'd0, b32.out_valid}, 64'd1);
        #2 rst = 1'b1;
        #1;
        check("rf_async_valid", {63'd0, b32.out_valid}, 64'd0);
        check("rf_async_out", {32'd0, b32.out}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        b32.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check($sformatf("rf_no_stale%0d", i), {63'd0, b32.out_valid}, 64'd0);
        end
        run32("rf_next_op", 1'b0, 32'h40000000, 32'h40000000, 32'h40800000, 4'b0000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
